// File: rtl/baud_tick_gen.sv
// Single-cycle tick-enable baud source (oversample, bit and mid-bit ticks) with a shadowed divisor.
// Define BAUD_GEN_FRAC_EN to enable the fractional accumulator driven by div_frac_in.
module baud_tick_gen #(
  parameter int unsigned CLOCK_IN          = 100_000_000,
  parameter int unsigned BAUD_RATE         = 230_400,
  parameter int unsigned OVERSAMPLING_RATE = 8,
  parameter int unsigned DIV_W             = 16,
  parameter int unsigned FRAC_W            = 4
) (
  input  logic                                 clk_in,
  input  logic                                 nrst_in,
  input  logic                                 en_in,
  input  logic                                 sync_in,
  input  logic                                 div_load_in,
  input  logic [DIV_W-1:0]                     div_int_in,
  input  logic [FRAC_W-1:0]                    div_frac_in,
  output logic                                 div_pending_out,
  output logic                                 os_tick_out,
  output logic                                 bit_tick_out,
  output logic                                 mid_tick_out,
  output logic [$clog2(OVERSAMPLING_RATE)-1:0] sample_idx_out
);

  localparam int unsigned IDX_W = $clog2(OVERSAMPLING_RATE);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(OVERSAMPLING_RATE - 1);
  localparam logic [IDX_W-1:0] IDX_PRE_MID  = IDX_W'(OVERSAMPLING_RATE / 2 - 1);
  localparam logic [63:0]      OS_BAUD      = 64'(OVERSAMPLING_RATE) * 64'(BAUD_RATE);

`ifdef BAUD_GEN_FRAC_EN
  localparam logic [63:0]       RST_Q        = (64'(CLOCK_IN) << FRAC_W) / OS_BAUD;
  localparam logic [DIV_W-1:0]  DIV_INT_RST  = DIV_W'(RST_Q >> FRAC_W);
  localparam logic [FRAC_W-1:0] DIV_FRAC_RST = FRAC_W'(RST_Q);
`else
  localparam logic [DIV_W-1:0]  DIV_INT_RST  = DIV_W'((64'(CLOCK_IN) + OS_BAUD / 2) / OS_BAUD);
`endif

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] act_int;
  logic [DIV_W-1:0] shd_int;
  logic [DIV_W-1:0] eff_int;
  logic [DIV_W:0]   period;
  logic [IDX_W-1:0] idx;
  logic             pend;
  logic             terminal;
  logic             boundary;

  assign eff_int = (act_int == '0) ? DIV_W'(1) : act_int;

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] shd_frac;
  logic [FRAC_W:0]   acc_sum;

  // The carry of acc + frac stretches the current period by one cycle.
  assign acc_sum = {1'b0, acc} + {1'b0, act_frac};
  assign period  = {1'b0, eff_int} + (DIV_W + 1)'(acc_sum[FRAC_W]);
`else
  logic unused_frac;

  assign unused_frac = ^div_frac_in;
  assign period      = {1'b0, eff_int};
`endif

  assign terminal = en_in && !sync_in && ({1'b0, cnt} == period - (DIV_W + 1)'(1));
  assign boundary = sync_in || terminal;
  assign sample_idx_out = idx;

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      cnt          <= '0;
      idx          <= '0;
      os_tick_out  <= 1'b0;
      bit_tick_out <= 1'b0;
      mid_tick_out <= 1'b0;
    end else begin
      os_tick_out  <= terminal;
      bit_tick_out <= terminal && (idx == IDX_LAST);
      mid_tick_out <= terminal && (idx == IDX_PRE_MID);
      if (sync_in) begin
        cnt <= '0;
        idx <= '0;
      end else if (terminal) begin
        cnt <= '0;
        idx <= idx + 1'b1;
      end else if (en_in) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A load coinciding with a boundary lands in the shadow and waits for the next one.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      act_int         <= DIV_INT_RST;
      shd_int         <= DIV_INT_RST;
      pend            <= 1'b0;
      div_pending_out <= 1'b0;
    end else begin
      if (boundary && pend) act_int <= shd_int;
      if (div_load_in) begin
        shd_int         <= div_int_in;
        pend            <= 1'b1;
        div_pending_out <= 1'b1;
      end else if (boundary) begin
        pend            <= 1'b0;
        div_pending_out <= 1'b0;
      end
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      acc      <= '0;
      act_frac <= DIV_FRAC_RST;
      shd_frac <= DIV_FRAC_RST;
    end else begin
      if (sync_in)       acc <= '0;
      else if (terminal) acc <= acc_sum[FRAC_W-1:0];
      if (boundary && pend) act_frac <= shd_frac;
      if (div_load_in)      shd_frac <= div_frac_in;
    end
  end
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a period-level behavioural model.
module tb_baud_tick_gen;

  localparam int OS     = 8;
  localparam int FSCALE = 16;
`ifdef BAUD_GEN_FRAC_EN
  localparam int RST_INT = 54, RST_FRAC = 4, T64 = 3472, T16_LOAD = 88;
`else
  localparam int RST_INT = 54, RST_FRAC = 0, T64 = 3456, T16_LOAD = 80;
`endif

  logic        clk_in = 1'b0;
  logic        nrst_in = 1'b0;
  logic        en_in = 1'b0;
  logic        sync_in = 1'b0;
  logic        div_load_in = 1'b0;
  logic [15:0] div_int_in = '0;
  logic [3:0]  div_frac_in = '0;
  logic        div_pending_out, os_tick_out, bit_tick_out, mid_tick_out;
  logic [2:0]  sample_idx_out;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  baud_tick_gen dut (
    .clk_in(clk_in), .nrst_in(nrst_in), .en_in(en_in), .sync_in(sync_in),
    .div_load_in(div_load_in), .div_int_in(div_int_in), .div_frac_in(div_frac_in),
    .div_pending_out(div_pending_out), .os_tick_out(os_tick_out),
    .bit_tick_out(bit_tick_out), .mid_tick_out(mid_tick_out),
    .sample_idx_out(sample_idx_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: whole periods, a tick count since the last sync/reset, and the divisor pair.
  int m_int, m_frac, s_int, s_frac, m_acc, m_plen, m_elapsed, m_ticks;
  bit m_pend, e_os, e_bit, e_mid;

  function automatic void start_period();
    int eff;
    int sum;
    eff = (m_int == 0) ? 1 : m_int;
`ifdef BAUD_GEN_FRAC_EN
    sum    = m_acc + m_frac;
    m_plen = eff + sum / FSCALE;
    m_acc  = sum % FSCALE;
`else
    sum    = m_frac;
    m_plen = eff;
`endif
  endfunction

  function automatic void model_reset();
    m_int = RST_INT; m_frac = RST_FRAC; s_int = RST_INT; s_frac = RST_FRAC;
    m_pend = 0; m_acc = 0; m_elapsed = 0; m_ticks = 0;
    e_os = 0; e_bit = 0; e_mid = 0;
    start_period();
  endfunction

  always @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) model_reset();
    else begin
      bit bnd;
      bnd = 0; e_os = 0; e_bit = 0; e_mid = 0;
      if (sync_in) begin
        m_elapsed = 0; m_ticks = 0; m_acc = 0; bnd = 1;
      end else if (en_in) begin
        m_elapsed++;
        if (m_elapsed >= m_plen) begin
          m_elapsed = 0; m_ticks++; bnd = 1;
          e_os  = 1;
          e_bit = (m_ticks % OS == 0);
          e_mid = (m_ticks % OS == OS / 2);
        end
      end
      if (bnd && m_pend) begin m_int = s_int; m_frac = s_frac; end
      if (div_load_in) begin
        s_int = int'(div_int_in); s_frac = int'(div_frac_in); m_pend = 1;
      end else if (bnd) m_pend = 0;
      if (bnd) start_period();
    end
  end

  always @(posedge clk_in) begin
    #2;
    chk("os_tick", os_tick_out, e_os);
    chk("bit_tick", bit_tick_out, e_bit);
    chk("mid_tick", mid_tick_out, e_mid);
    chk("sample_idx", sample_idx_out, m_ticks % OS);
    chk("div_pending", div_pending_out, m_pend);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_tick(input int limit, output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!os_tick_out && edges < limit);
    if (!os_tick_out) chk("tick_timeout", 0, 1);
  endtask

  task automatic load(input int i, input int f);
    div_int_in = 16'(i); div_frac_in = 4'(f); div_load_in = 1'b1;
    step();
    div_load_in = 1'b0;
  endtask

  initial begin
    int e, total, bits, highs, quiet;
    repeat (3) @(posedge clk_in);
    #1 nrst_in = 1'b1;
    step(); step();
    chk("rst_os", os_tick_out, 0);
    chk("rst_pending", div_pending_out, 0);
    chk("rst_idx", sample_idx_out, 0);

    en_in = 1'b1;
    total = 0; bits = 0;
    for (int k = 1; k <= 64; k++) begin
      wait_tick(200, e);
      if (k == 1) chk("first_tick_edges", e, 54);
      total += e;
      if (bit_tick_out) bits++;
    end
    chk("edges_for_64_ticks", total, T64);
    chk("bit_ticks_in_64", bits, 8);

    load(5, 8);
    chk("pending_after_load", div_pending_out, 1);
    wait_tick(200, e);
    chk("pending_cleared_at_boundary", div_pending_out, 0);
    total = 0;
    for (int k = 1; k <= 16; k++) begin wait_tick(20, e); total += e; end
    chk("edges_for_16_ticks_5_8", total, T16_LOAD);

    load(10, 0);
    repeat (3) step();
    sync_in = 1'b1; step(); sync_in = 1'b0;
    chk("no_tick_after_sync", os_tick_out, 0);
    chk("pending_applied_by_sync", div_pending_out, 0);
    for (int k = 1; k <= 8; k++) begin
      wait_tick(30, e);
      chk("sync_tick_spacing", e, 10);
      chk("sync_idx", sample_idx_out, k % 8);
      chk("sync_mid", mid_tick_out, (k == 4));
      chk("sync_bit", bit_tick_out, (k == 8));
    end

    sync_in = 1'b1; step(); sync_in = 1'b0;
    repeat (3) step();
    en_in = 1'b0; quiet = 0;
    repeat (7) begin step(); if (os_tick_out || bit_tick_out || mid_tick_out) quiet++; end
    chk("ticks_while_disabled", quiet, 0);
    en_in = 1'b1;
    wait_tick(30, e);
    chk("tick_after_pause", e, 7);

    for (int d = 1; d >= 0; d--) begin
      load(d, 0);
      wait_tick(30, e);
      highs = 0; bits = 0;
      repeat (16) begin step(); highs += os_tick_out; bits += bit_tick_out; end
      chk("os_high_every_cycle", highs, 16);
      chk("bit_every_8", bits, 2);
    end

    load(9, 0);
    chk("pending_before_reset", div_pending_out, 1);
    #2 nrst_in = 1'b0;
    #1;
    chk("async_rst_os", os_tick_out, 0);
    chk("async_rst_bit", bit_tick_out, 0);
    chk("async_rst_mid", mid_tick_out, 0);
    chk("async_rst_idx", sample_idx_out, 0);
    chk("async_rst_pending", div_pending_out, 0);
    en_in = 1'b0;
    step(); step();
    #2 nrst_in = 1'b1;
    step();
    en_in = 1'b1;
    wait_tick(100, e);
    chk("first_tick_after_reset", e, 54);

    for (int i = 0; i < 2500; i++) begin
      en_in       = ($urandom_range(0, 99) < 85);
      sync_in     = ($urandom_range(0, 99) < 2);
      div_load_in = ($urandom_range(0, 99) < 4);
      div_int_in  = 16'($urandom_range(0, 12));
      div_frac_in = 4'($urandom);
      step();
    end
    en_in = 1'b0; sync_in = 1'b0; div_load_in = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
